// File: rtl/acc_sched_pkg.sv
// Shared types and default constants for the accumulator job scheduler.
package acc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_IDLE = 3'd3,
    HALT      = 3'd4
  } sched_state_e;

  localparam int DEF_CNT_BIT     = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_JOBS_W      = 16;
  localparam int DEF_WDOG_CYCLES = 1024;

endpackage

// File: rtl/acc_job_fifo.sv
// Job queue: DEPTH x W registered storage, pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter.
module acc_job_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/acc_job_scheduler.sv
// Accumulator job scheduler: queues run counts and launches them one at a time.
// Optional watchdog on WAIT_DONE is enabled with macro ACC_SCHED_WDOG_EN.
module acc_job_scheduler
  import acc_sched_pkg::*;
#(
  parameter int CNT_BIT     = DEF_CNT_BIT,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int JOBS_W      = DEF_JOBS_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [CNT_BIT-1:0]       push_count_i,
  output logic                     start_run_o,
  output logic [CNT_BIT-1:0]       run_count_o,
  input  logic                     acc_idle_i,
  input  logic                     acc_done_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [JOBS_W-1:0]        jobs_done_o,
  output logic                     err_o,
  input  logic                     clear_err_i
);

  sched_state_e       state_q, state_d;
  logic [CNT_BIT-1:0] run_count_q, run_count_d;
  logic [JOBS_W-1:0]  jobs_q, jobs_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CNT_BIT-1:0] fifo_head;

  assign push_ready_o = !fifo_full;

  acc_job_fifo #(
    .W     (CNT_BIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_valid_i && push_ready_o),
    .pop_i   (fifo_pop),
    .data_i  (push_count_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

`ifdef ACC_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  assign err_o = err_q;
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err_i;
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    run_count_d = run_count_q;
    jobs_d      = jobs_q;
    fifo_pop    = 1'b0;
`ifdef ACC_SCHED_WDOG_EN
    wdog_d      = '0;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Zero-count jobs are popped and dropped without a launch.
        if (!fifo_empty && acc_idle_i) begin
          fifo_pop = 1'b1;
          if (fifo_head != '0) begin
            state_d     = LAUNCH;
            run_count_d = fifo_head;
          end
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (acc_done_i) begin
          jobs_d  = jobs_q + JOBS_W'(1);
          state_d = WAIT_IDLE;
        end
`ifdef ACC_SCHED_WDOG_EN
        else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
`endif
      end
      WAIT_IDLE: if (acc_idle_i) state_d = IDLE;
      HALT: begin
`ifdef ACC_SCHED_WDOG_EN
        if (clear_err_i) begin
          err_d   = 1'b0;
          state_d = WAIT_IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      run_count_q <= '0;
      jobs_q      <= '0;
`ifdef ACC_SCHED_WDOG_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      run_count_q <= run_count_d;
      jobs_q      <= jobs_d;
`ifdef ACC_SCHED_WDOG_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  assign start_run_o = (state_q == LAUNCH);
  assign run_count_o = run_count_q;
  assign jobs_done_o = jobs_q;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Directed self-checking bench for acc_job_scheduler (default build, plus a
// watchdog section when ACC_SCHED_WDOG_EN is defined).
module tb_acc_job_scheduler;

`ifdef ACC_SCHED_WDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pushValid = 1'b0;
  logic [7:0]  pushCount = '0;
  logic        tbIdle = 1'b1, tbDone = 1'b0, clearErr = 1'b0, autoAcc = 1'b0;
  logic        modelIdle = 1'b1, modelDone = 1'b0;
  int          busyCnt = 0;
  logic        push_ready, start_run, busy, err;
  logic [7:0]  run_count;
  logic [2:0]  level;
  logic [15:0] jobs_done;
  logic        acc_idle, acc_done;

  int checks = 0, passes = 0, startCount = 0, base = 0;
  int runLog[$];

  assign acc_idle = autoAcc ? modelIdle : tbIdle;
  assign acc_done = autoAcc ? modelDone : tbDone;

  always #5 clk = ~clk;

  acc_job_scheduler #(
    .CNT_BIT(8), .DEPTH(4), .JOBS_W(16), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid_i(pushValid), .push_ready_o(push_ready), .push_count_i(pushCount),
    .start_run_o(start_run), .run_count_o(run_count),
    .acc_idle_i(acc_idle), .acc_done_i(acc_done),
    .busy_o(busy), .level_o(level), .jobs_done_o(jobs_done),
    .err_o(err), .clear_err_i(clearErr)
  );

  // Datapath model: busy for three cycles after a start, then done, then idle.
  always @(negedge clk) begin
    if (!autoAcc) begin
      modelIdle = 1'b1; modelDone = 1'b0; busyCnt = 0;
    end else if (start_run) begin
      modelIdle = 1'b0; busyCnt = 3;
    end else if (busyCnt > 0) begin
      busyCnt = busyCnt - 1;
      if (busyCnt == 0) modelDone = 1'b1;
    end else if (modelDone) begin
      modelDone = 1'b0; modelIdle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (start_run) begin
      startCount = startCount + 1;
      runLog.push_back(int'(run_count));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] count);
    @(negedge clk);
    pushValid = 1'b1; pushCount = count;
    @(negedge clk);
    pushValid = 1'b0;
  endtask

  task automatic waitJobs(input int target);
    for (int i = 0; i < 200; i++) begin
      if (int'(jobs_done) == target) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, push_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_start"}, start_run, 0);
    checkOutput({tag, "_runcnt"}, run_count, 0);
    checkOutput({tag, "_jobs"}, jobs_done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    // Reset state
    #3;
    checkResetValues("rst");
    @(negedge clk); reset_n = 1'b1;

    // Two jobs, 5 then 3, with the datapath model running
    autoAcc = 1'b1;
    applyStimulus(8'd5);
    applyStimulus(8'd3);
    waitJobs(2);
    checkOutput("two_starts", startCount, 2);
    checkOutput("two_run0", runLog[0], 5);
    checkOutput("two_run1", runLog[1], 3);
    checkOutput("two_jobs", jobs_done, 2);
    checkOutput("two_busy", busy, 0);
    checkOutput("two_runhold", run_count, 3);

    // Done pulsed while idle must not count
    autoAcc = 1'b0; tbIdle = 1'b1;
    @(negedge clk); tbDone = 1'b1;
    @(negedge clk); tbDone = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_done_jobs", jobs_done, 2);
    checkOutput("idle_done_starts", startCount, 2);

    // Zero-count job is dropped, the following one runs
    base = startCount;
    autoAcc = 1'b1;
    applyStimulus(8'd0);
    applyStimulus(8'd7);
    waitJobs(3);
    checkOutput("zero_starts", startCount - base, 1);
    checkOutput("zero_run", runLog[base], 7);
    checkOutput("zero_jobs", jobs_done, 3);

    // Fill the queue with the datapath busy, fifth push held off
    autoAcc = 1'b0; tbIdle = 1'b0;
    base = startCount;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); pushValid = 1'b1; pushCount = 8'(i);
    end
    @(negedge clk); pushValid = 1'b0;
    checkOutput("full_level", level, 4);
    checkOutput("full_ready", push_ready, 0);
    checkOutput("full_busy", busy, 1);
    pushValid = 1'b1; pushCount = 8'd9;
    repeat (2) @(negedge clk);
    pushValid = 1'b0;
    checkOutput("full_held_level", level, 4);
    checkOutput("full_held_starts", startCount - base, 0);
    autoAcc = 1'b1;
    waitJobs(7);
    checkOutput("drain_starts", startCount - base, 4);
    checkOutput("drain_run0", runLog[base], 1);
    checkOutput("drain_run3", runLog[base + 3], 4);
    checkOutput("drain_jobs", jobs_done, 7);
    checkOutput("drain_level", level, 0);

    // Reset in WAIT_DONE with two jobs queued
    autoAcc = 1'b0; tbIdle = 1'b1; tbDone = 1'b0;
    base = startCount;
    @(negedge clk); pushValid = 1'b1; pushCount = 8'd6;
    @(negedge clk); pushCount = 8'd7;
    @(negedge clk); pushCount = 8'd8;
    @(negedge clk); pushValid = 1'b0;
    checkOutput("mid_level", level, 2);
    checkOutput("mid_starts", startCount - base, 1);
    checkOutput("mid_runcnt", run_count, 6);
    checkOutput("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk); reset_n = 1'b1;
    base = startCount;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_starts", startCount - base, 0);
    checkOutput("post_rst_busy", busy, 0);
    autoAcc = 1'b1;
    applyStimulus(8'd2);
    waitJobs(1);
    checkOutput("post_rst_new_starts", startCount - base, 1);
    checkOutput("post_rst_new_run", run_count, 2);
    checkOutput("post_rst_jobs", jobs_done, 1);
    checkOutput("dflt_err", err, 0);

`ifdef ACC_SCHED_WDOG_EN
    // Watchdog: done withheld for WDOG cycles in WAIT_DONE
    autoAcc = 1'b0; tbIdle = 1'b1; tbDone = 1'b0;
    base = startCount;
    applyStimulus(8'd5);
    for (int i = 0; i < 20; i++) begin
      if (start_run) break;
      @(negedge clk);
    end
    checkOutput("wd_start", start_run, 1);
    repeat (16) @(negedge clk);
    checkOutput("wd_err_early", err, 0);
    @(negedge clk);
    checkOutput("wd_err_set", err, 1);
    applyStimulus(8'd9);
    repeat (5) @(negedge clk);
    checkOutput("wd_halt_starts", startCount - base, 1);
    checkOutput("wd_halt_level", level, 1);
    checkOutput("wd_err_sticky", err, 1);
    clearErr = 1'b1;
    @(negedge clk); clearErr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_run) break;
      @(negedge clk);
    end
    checkOutput("wd_relaunch", start_run, 1);
    checkOutput("wd_relaunch_run", run_count, 9);
    checkOutput("wd_err_clear", err, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
